// File: rtl/pipe_ctrl_pkg.sv
// Shared decode codes, PC select encodings and controller state type.
package pipe_ctrl_pkg;

    // First-level decode classes
    localparam logic [1:0] FIRST_LD_DIMM = 2'b00;
    localparam logic [1:0] FIRST_LD_DREG = 2'b01;
    localparam logic [1:0] FIRST_LD_LDST = 2'b10;
    localparam logic [1:0] FIRST_LD_SYS  = 2'b11;

    // Second-level decode within the system/branch class
    localparam logic [3:0] SLD_B     = 4'b0000;
    localparam logic [3:0] SLD_BCOND = 4'b0001;
    localparam logic [3:0] SLD_BR    = 4'b0010;

    // PC mux select
    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_ID  = 2'b01;
    localparam logic [1:0] PC_SEL_EX  = 2'b10;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up/down counter; holds at all-ones and at zero.
module sat_counter #(
    parameter int             W    = 2,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Step toward the requested direction unless already at the rail
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= INIT;
        else if (i_inc && !i_dec && (r_q != {W{1'b1}}))
            r_q <= r_q + W'(1);
        else if (i_dec && !i_inc && (r_q != {W{1'b0}}))
            r_q <= r_q - W'(1);
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stalls, branch redirect, mispredict
// recovery and HALT draining for the IF/ID/EX datapath.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int         PC_W         = 32,
    parameter int         CNT_W        = 16,
    parameter logic [1:0] PRED_INIT    = 2'b01,
    parameter int         DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_first_ld,
    input  logic [3:0]       id_second_ld,
    input  logic [3:0]       id_dest_reg,
    input  logic [3:0]       id_op1_reg,
    input  logic [3:0]       id_op2_reg,
    input  logic [2:0]       id_pointer_reg,
    input  logic [PC_W-1:0]  id_target,
    input  logic             ex_is_load,
    input  logic [3:0]       ex_dest_reg,
    input  logic             ex_br_valid,
    input  logic             ex_br_taken,
    input  logic             ex_br_pred,
    input  logic [PC_W-1:0]  ex_redirect_pc,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             id_pred_taken,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    ctrl_state_t   r_state, w_state_nxt;
    logic [DW-1:0] r_drain_cnt, w_drain_nxt;
    logic [1:0]    w_pred;
    logic          w_stall_inc, w_mis_inc, w_pred_upd;

    // Targets are muxed in the datapath; ID destination is not a hazard source here
    logic w_unused;
    assign w_unused = ^{id_target, ex_redirect_pc, id_dest_reg};

    // Instruction classes in ID
    logic w_sys, w_is_b, w_is_cond, w_is_br, w_is_halt;
    assign w_sys     = id_valid && (id_first_ld == FIRST_LD_SYS);
    assign w_is_b    = w_sys && (id_second_ld == SLD_B);
    assign w_is_cond = w_sys && (id_second_ld == SLD_BCOND);
    assign w_is_br   = w_sys && (id_second_ld == SLD_BR);
    assign w_is_halt = w_sys && id_second_ld[3] && !id_second_ld[2];

    // Load-use: EX load writes a register ID is about to read
    logic w_ld_wr, w_hit_op1, w_hit_op2, w_hit_ptr, w_hazard;
    assign w_ld_wr   = ex_is_load && ex_dest_reg[3];
    assign w_hit_op1 = id_op1_reg[3] && (id_op1_reg[2:0] == ex_dest_reg[2:0]);
    assign w_hit_op2 = id_op2_reg[3] && (id_op2_reg[2:0] == ex_dest_reg[2:0]);
    assign w_hit_ptr = ((id_first_ld == FIRST_LD_LDST) || w_is_br)
                       && (id_pointer_reg == ex_dest_reg[2:0]);
    assign w_hazard  = id_valid && w_ld_wr && (w_hit_op1 || w_hit_op2 || w_hit_ptr);

    logic w_mispred;
    assign w_mispred = ex_br_valid && (ex_br_taken != ex_br_pred);

    // Predictor trains in RUN and DRAIN only; frozen once halted
    assign w_pred_upd = ex_br_valid && ((r_state == ST_RUN) || (r_state == ST_DRAIN));

    sat_counter #(.W(2), .INIT(PRED_INIT)) u_pred (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (w_pred_upd && ex_br_taken),
        .i_dec   (w_pred_upd && !ex_br_taken),
        .o_q     (w_pred)
    );

    sat_counter #(.W(CNT_W), .INIT('0)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (w_stall_inc),
        .i_dec   (1'b0),
        .o_q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W), .INIT('0)) u_mispred_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_inc   (w_mis_inc),
        .i_dec   (1'b0),
        .o_q     (mispred_cnt)
    );

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Next state and control outputs; defaults are the "safe" NOP-everything values
    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = '0;
        pc_we         = 1'b0;
        pc_sel        = PC_SEL_SEQ;
        ifid_we       = 1'b0;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        id_pred_taken = 1'b0;
        halted        = 1'b0;
        w_stall_inc   = 1'b0;
        w_mis_inc     = 1'b0;
        case (r_state)
            ST_RESET: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_mispred) begin
                    pc_we     = 1'b1;
                    pc_sel    = PC_SEL_EX;
                    w_mis_inc = 1'b1;
                end else if (w_hazard) begin
                    ifid_flush  = 1'b0;
                    w_stall_inc = 1'b1;
                end else if (w_is_b || (w_is_cond && w_pred[1])) begin
                    pc_we         = 1'b1;
                    pc_sel        = PC_SEL_ID;
                    idex_bubble   = 1'b0;
                    id_pred_taken = w_is_cond ? w_pred[1] : 1'b1;
                end else if (w_is_halt) begin
                    idex_bubble = 1'b0;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    pc_we         = 1'b1;
                    ifid_we       = 1'b1;
                    ifid_flush    = 1'b0;
                    idex_bubble   = 1'b0;
                    id_pred_taken = w_is_cond && w_pred[1];
                end
            end
            ST_DRAIN: begin
                if (w_mispred) begin
                    // HALT was on the wrong path: recover and resume
                    pc_we       = 1'b1;
                    pc_sel      = PC_SEL_EX;
                    w_mis_inc   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_drain_nxt = r_drain_cnt + DW'(1);
                    if (r_drain_cnt == DRAIN_LAST)
                        w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: halted = 1'b1;
            default:   w_state_nxt = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use, prediction, mispredict,
// HALT draining, counter saturation and asynchronous reset.
module tb_pipe_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    // ctrl = {pc_we, pc_sel[1:0], ifid_we, ifid_flush, idex_bubble, id_pred_taken, halted}
    localparam logic [7:0] C_RST = 8'b0000_1100;
    localparam logic [7:0] C_RUN = 8'b1001_0000;
    localparam logic [7:0] C_STL = 8'b0000_0100;
    localparam logic [7:0] C_MIS = 8'b1100_1100;
    localparam logic [7:0] C_RDR = 8'b1010_1010;
    localparam logic [7:0] C_HLT = 8'b0000_1000;
    localparam logic [7:0] C_DRN = 8'b0000_1100;
    localparam logic [7:0] C_HTD = 8'b0000_1101;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [1:0]       id_first_ld;
    logic [3:0]       id_second_ld;
    logic [3:0]       id_dest_reg;
    logic [3:0]       id_op1_reg;
    logic [3:0]       id_op2_reg;
    logic [2:0]       id_pointer_reg;
    logic [PC_W-1:0]  id_target;
    logic             ex_is_load;
    logic [3:0]       ex_dest_reg;
    logic             ex_br_valid;
    logic             ex_br_taken;
    logic             ex_br_pred;
    logic [PC_W-1:0]  ex_redirect_pc;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             id_pred_taken;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic [7:0]       ctrl;

    int checks   = 0;
    int failures = 0;

    assign ctrl = {pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, id_pred_taken, halted};

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .PRED_INIT(2'b01), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_first_ld(id_first_ld), .id_second_ld(id_second_ld),
        .id_dest_reg(id_dest_reg), .id_op1_reg(id_op1_reg), .id_op2_reg(id_op2_reg),
        .id_pointer_reg(id_pointer_reg), .id_target(id_target),
        .ex_is_load(ex_is_load), .ex_dest_reg(ex_dest_reg),
        .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken), .ex_br_pred(ex_br_pred),
        .ex_redirect_pc(ex_redirect_pc),
        .pc_we(pc_we), .pc_sel(pc_sel), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .id_pred_taken(id_pred_taken), .halted(halted),
        .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid       = 1'b0;
        id_first_ld    = 2'b00;
        id_second_ld   = 4'b0000;
        id_dest_reg    = 4'b0000;
        id_op1_reg     = 4'b0000;
        id_op2_reg     = 4'b0000;
        id_pointer_reg = 3'b000;
        id_target      = 32'h0000_1000;
        ex_is_load     = 1'b0;
        ex_dest_reg    = 4'b0000;
        ex_br_valid    = 1'b0;
        ex_br_taken    = 1'b0;
        ex_br_pred     = 1'b0;
        ex_redirect_pc = 32'h0000_2000;
    endtask

    // Assert reset mid-cycle, release between edges; leaves DUT in RESET state
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_inputs();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_RST) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RST); end
        checks++;
        if (stall_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
            failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, mispred_cnt);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctrl !== C_RST) begin failures++; $display("FAIL rst_cycle0 got=%b exp=%b", ctrl, C_RST); end
        tick();
        checks++;
        if (ctrl !== C_RUN) begin failures++; $display("FAIL rst_cycle1 got=%b exp=%b", ctrl, C_RUN); end
        tick();
        checks++;
        if (ctrl !== C_RUN) begin failures++; $display("FAIL rst_cycle2 got=%b exp=%b", ctrl, C_RUN); end
    endtask

    task automatic test_load_use();
        // op1 = r3 with load to r3 in EX
        id_valid = 1'b1; id_first_ld = 2'b01; id_op1_reg = 4'b1011;
        ex_is_load = 1'b1; ex_dest_reg = 4'b1011;
        #1;
        checks++;
        if (ctrl !== C_STL) begin failures++; $display("FAIL lu_stall got=%b exp=%b", ctrl, C_STL); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        checks++;
        if (ctrl !== C_RUN) begin failures++; $display("FAIL lu_resume got=%b exp=%b", ctrl, C_RUN); end
        // same register but read enable off
        id_valid = 1'b1; id_first_ld = 2'b01; id_op1_reg = 4'b0011;
        ex_is_load = 1'b1; ex_dest_reg = 4'b1011;
        #1;
        checks++;
        if (ctrl !== C_RUN) begin failures++; $display("FAIL lu_noen got=%b exp=%b", ctrl, C_RUN); end
        tick();
        clear_inputs();
        // load/store pointer register dependency
        id_valid = 1'b1; id_first_ld = 2'b10; id_pointer_reg = 3'd3;
        ex_is_load = 1'b1; ex_dest_reg = 4'b1011;
        #1;
        checks++;
        if (ctrl !== C_STL) begin failures++; $display("FAIL lu_ptr got=%b exp=%b", ctrl, C_STL); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 16'd2) begin failures++; $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_branch();
        // predictor 01: cond branch falls through
        id_valid = 1'b1; id_first_ld = 2'b11; id_second_ld = 4'b0001;
        #1;
        checks++;
        if (ctrl !== C_RUN) begin failures++; $display("FAIL br_nt got=%b exp=%b", ctrl, C_RUN); end
        tick();
        clear_inputs();
        ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_pred = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_MIS) begin failures++; $display("FAIL br_mis got=%b exp=%b", ctrl, C_MIS); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (mispred_cnt !== 16'd1) begin failures++; $display("FAIL br_miscnt got=%0d exp=1", mispred_cnt); end
        // predictor now 10: cond branch redirects from ID
        id_valid = 1'b1; id_first_ld = 2'b11; id_second_ld = 4'b0001;
        #1;
        checks++;
        if (ctrl !== C_RDR) begin failures++; $display("FAIL br_tk got=%b exp=%b", ctrl, C_RDR); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mispred_priority();
        ex_br_valid = 1'b1; ex_br_taken = 1'b0; ex_br_pred = 1'b1;
        ex_is_load = 1'b1; ex_dest_reg = 4'b1011;
        id_valid = 1'b1; id_first_ld = 2'b11; id_second_ld = 4'b0000; id_op1_reg = 4'b1011;
        #1;
        checks++;
        if (ctrl !== C_MIS) begin failures++; $display("FAIL prio_ctrl got=%b exp=%b", ctrl, C_MIS); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 16'd2 || mispred_cnt !== 16'd2) begin
            failures++; $display("FAIL prio_cnt got=%0d/%0d exp=2/2", stall_cnt, mispred_cnt);
        end
    endtask

    task automatic test_halt();
        id_valid = 1'b1; id_first_ld = 2'b11; id_second_ld = 4'b1000;
        #1;
        checks++;
        if (ctrl !== C_HLT) begin failures++; $display("FAIL halt_id got=%b exp=%b", ctrl, C_HLT); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (ctrl !== C_DRN) begin failures++; $display("FAIL drain0 got=%b exp=%b", ctrl, C_DRN); end
        tick();
        checks++;
        if (ctrl !== C_DRN) begin failures++; $display("FAIL drain1 got=%b exp=%b", ctrl, C_DRN); end
        tick();
        checks++;
        if (ctrl !== C_HTD) begin failures++; $display("FAIL halted got=%b exp=%b", ctrl, C_HTD); end
        for (int i = 0; i < 20; i++) begin
            id_valid       = 1'($urandom);
            id_first_ld    = 2'($urandom);
            id_second_ld   = 4'($urandom);
            id_op1_reg     = 4'($urandom);
            id_op2_reg     = 4'($urandom);
            id_pointer_reg = 3'($urandom);
            ex_is_load     = 1'($urandom);
            ex_dest_reg    = 4'($urandom);
            ex_br_valid    = 1'($urandom);
            ex_br_taken    = 1'($urandom);
            ex_br_pred     = 1'($urandom);
            #1;
            checks++;
            if (ctrl !== C_HTD || stall_cnt !== 16'd2 || mispred_cnt !== 16'd2) begin
                failures++;
                $display("FAIL halted_hold[%0d] got=%b %0d/%0d exp=%b 2/2", i, ctrl, stall_cnt, mispred_cnt, C_HTD);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_halt_mispred();
        do_reset();
        tick();
        id_valid = 1'b1; id_first_ld = 2'b11; id_second_ld = 4'b1001;
        #1;
        checks++;
        if (ctrl !== C_HLT) begin failures++; $display("FAIL hm_id got=%b exp=%b", ctrl, C_HLT); end
        tick();
        clear_inputs();
        ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_pred = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_MIS) begin failures++; $display("FAIL hm_mis got=%b exp=%b", ctrl, C_MIS); end
        tick();
        clear_inputs();
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctrl !== C_RUN) begin failures++; $display("FAIL hm_run[%0d] got=%b exp=%b", i, ctrl, C_RUN); end
            tick();
        end
        checks++;
        if (mispred_cnt !== 16'd1) begin failures++; $display("FAIL hm_cnt got=%0d exp=1", mispred_cnt); end
    endtask

    task automatic test_saturate_and_async_reset();
        id_valid = 1'b1; id_first_ld = 2'b01; id_op2_reg = 4'b1101;
        ex_is_load = 1'b1; ex_dest_reg = 4'b1101;
        repeat ((1 << CNT_W) + 5) tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt got=%h exp=ffff", stall_cnt); end
        id_valid = 1'b1; id_first_ld = 2'b11; id_second_ld = 4'b1010;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (ctrl !== C_DRN) begin failures++; $display("FAIL sat_drain got=%b exp=%b", ctrl, C_DRN); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_RST || stall_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
            failures++;
            $display("FAIL async_rst got=%b %h/%h exp=%b 0/0", ctrl, stall_cnt, mispred_cnt, C_RST);
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mispred_priority();
        test_halt();
        test_halt_mispred();
        test_saturate_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
